clk_div_bank: RTL and testbench

Parametrised, fully synchronous clock-divider bank that generates `NUM_CH` derived clocks and matching one-cycle clock-enable strobes from a single reference clock. Each channel has a run-time programmable divide ratio, phase offset and high time. A lock sequencer realigns every channel and holds `locked` low until all outputs are phase-coherent. It sits downstream of the fixed-ratio PLL outputs and supplies slower, phase-related enables to the CORDIC datapath and its test logic without a new PLL instance per ratio.

---
 rtl/clk_div_bank.sv | 170 +++++++++++++++++
 tb/tb_clk_div_bank.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH programmable clock dividers driven from one
// reference clock. Each channel produces a registered divided clock and a
// one-cycle enable strobe in the first high cycle of that clock. A small
// sequencer realigns all channel counters after reset or any effective
// configuration write, then waits LOCK_CYCLES cycles before raising locked.
//
// Ports:
//   refclk     sole clock, all state on its rising edge
//   rst        asynchronous active-high reset
//   cfg_valid  configuration write request
//   cfg_ready  write accepted on an edge with cfg_valid & cfg_ready
//   cfg_ch     target channel (out-of-range index: accepted, ignored)
//   cfg_div    divide ratio (0 disables the channel, 1 passes enable through)
//   cfg_phase  rising-edge offset in refclk cycles
//   cfg_high   high time in refclk cycles
//   outclk     divided clocks
//   outce      enable strobes
//   locked     all channels aligned and stable
module clk_div_bank #(
   parameter int unsigned NUM_CH      = 2,
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned LOCK_CYCLES = 16,
   parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   input  logic [DIV_W-1:0]  cfg_high,
   output logic [NUM_CH-1:0] outclk,
   output logic [NUM_CH-1:0] outce,
   output logic              locked
);

   localparam int unsigned LockW = $clog2(LOCK_CYCLES + 1);
   localparam logic [DIV_W-1:0] One = DIV_W'(1);
   localparam logic [DIV_W-1:0] Two = DIV_W'(2);

   typedef enum logic [1:0] {StReset, StAlign, StLocking, StLocked} state_e;

   state_e             state_q, state_d;
   logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
   logic               wr_ok;
   logic [DIV_W-1:0]   new_phase, new_high;

   logic [DIV_W-1:0]   div_q   [NUM_CH];
   logic [DIV_W-1:0]   phase_q [NUM_CH];
   logic [DIV_W-1:0]   high_q  [NUM_CH];
   logic [DIV_W-1:0]   cnt_q   [NUM_CH];
   logic [DIV_W-1:0]   cnt_d   [NUM_CH];
   logic [DIV_W:0]     pos     [NUM_CH];
   logic [DIV_W:0]     cnt_inc [NUM_CH];
   logic [NUM_CH-1:0]  clk_d, ce_d;

   assign cfg_ready = (state_q == StLocking) || (state_q == StLocked);
   // Only in-range writes change state; out-of-range ones just complete the handshake.
   assign wr_ok = cfg_valid && cfg_ready && (32'(cfg_ch) < NUM_CH);

   // Clamp on store so the per-channel datapath never sees phase >= div or high = 0.
   always_comb begin
      new_phase = cfg_phase;
      if (cfg_phase >= cfg_div) begin
         new_phase = (cfg_div == '0) ? '0 : cfg_div - One;
      end
      new_high = (cfg_high == '0) ? One : cfg_high;
      if ((new_high >= cfg_div) && (cfg_div >= Two)) begin
         new_high = cfg_div - One;
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      unique case (state_q)
         StReset: state_d = StAlign;
         StAlign: begin
            state_d    = StLocking;
            lock_cnt_d = '0;
         end
         StLocking: begin
            if (wr_ok) begin
               state_d = StAlign;
            end else if (lock_cnt_q == LockW'(LOCK_CYCLES - 1)) begin
               state_d = StLocked;
            end else begin
               lock_cnt_d = lock_cnt_q + LockW'(1);
            end
         end
         StLocked: begin
            if (wr_ok) state_d = StAlign;
         end
         default: state_d = StReset;
      endcase
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q    <= StReset;
         lock_cnt_q <= '0;
         locked     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         locked     <= (state_d == StLocked);
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= Two;
            phase_q[i] <= '0;
            high_q[i]  <= One;
         end
      end else if (wr_ok) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
               div_q[i]   <= cfg_div;
               phase_q[i] <= new_phase;
               high_q[i]  <= new_high;
            end
         end
      end
   end

   // Per-channel counter and output decode; pos is the cycle index within
   // the period measured from the phase-shifted rising edge.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         pos[i]     = '0;
         cnt_inc[i] = {1'b0, cnt_q[i]} + (DIV_W + 1)'(1);
         cnt_d[i]   = (cnt_inc[i] >= {1'b0, div_q[i]}) ? '0 : cnt_q[i] + One;
         clk_d[i]   = 1'b0;
         ce_d[i]    = 1'b0;
         if (cnt_q[i] >= phase_q[i]) begin
            pos[i] = {1'b0, cnt_q[i]} - {1'b0, phase_q[i]};
         end else begin
            pos[i] = {1'b0, cnt_q[i]} + {1'b0, div_q[i]} - {1'b0, phase_q[i]};
         end
         if (div_q[i] == One) begin
            clk_d[i] = 1'b1;
            ce_d[i]  = 1'b1;
         end else if (div_q[i] != '0) begin
            clk_d[i] = (pos[i] < {1'b0, high_q[i]});
            ce_d[i]  = (pos[i] == '0);
         end
         if ((state_q == StReset) || (state_q == StAlign)) begin
            cnt_d[i] = '0;
            clk_d[i] = 1'b0;
            ce_d[i]  = 1'b0;
         end
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
         outclk <= '0;
         outce  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
         outclk <= clk_d;
         outce  <= ce_d;
      end
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank. A reference model computes, per
// refclk edge, the expected outputs in closed form from the time elapsed
// since the last realignment; a separate monitor compares each cycle.
module tb_clk_div_bank;

   localparam int NCH = 3;
   localparam int DW  = 8;
   localparam int LC  = 16;
   localparam int CW  = 2;

   logic           refclk = 1'b0;
   logic           rst = 1'b1;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [CW-1:0]  cfg_ch = '0;
   logic [DW-1:0]  cfg_div = '0;
   logic [DW-1:0]  cfg_phase = '0;
   logic [DW-1:0]  cfg_high = '0;
   logic [NCH-1:0] outclk, outce;
   logic           locked;

   clk_div_bank #(
      .NUM_CH(NCH), .DIV_W(DW), .LOCK_CYCLES(LC), .CH_W(CW)
   ) dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_high(cfg_high),
      .outclk(outclk), .outce(outce), .locked(locked)
   );

   always #5 refclk = ~refclk;

   typedef struct {
      logic [NCH-1:0] clk;
      logic [NCH-1:0] ce;
      logic           lck;
      logic           rdy;
      int             n;
   } exp_t;

   exp_t q[$];
   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp,
                        input int n);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s edge %0d: got %0h expected %0h", nm, n, act, exp);
      end
   endtask

   // Reference model: m_n = edges since reset release, m_a = edge at which
   // channel counters last restarted (ALIGN edge).
   int  m_n, m_a, k, cv, pv, d, p, h;
   int  m_div [NCH];
   int  m_ph  [NCH];
   int  m_hi  [NCH];
   bit  rb;
   exp_t e;

   always @(posedge refclk) begin
      e.clk = '0;
      e.ce  = '0;
      e.lck = 1'b0;
      e.rdy = 1'b0;
      if (rst) begin
         m_n = 0;
         m_a = 2;
         for (int c = 0; c < NCH; c++) begin
            m_div[c] = 2;
            m_ph[c]  = 0;
            m_hi[c]  = 1;
         end
      end else begin
         rb  = (m_n >= m_a);
         m_n = m_n + 1;
         for (int c = 0; c < NCH; c++) begin
            if (m_n > m_a && m_div[c] == 1) begin
               e.clk[c] = 1'b1;
               e.ce[c]  = 1'b1;
            end else if (m_n > m_a && m_div[c] >= 2) begin
               k  = m_n - m_a - 1;
               cv = k % m_div[c];
               pv = (cv - m_ph[c] + m_div[c]) % m_div[c];
               e.clk[c] = (pv < m_hi[c]);
               e.ce[c]  = (pv == 0);
            end
         end
         if (cfg_valid && rb && int'(cfg_ch) < NCH) begin
            d = int'(cfg_div);
            p = int'(cfg_phase);
            h = int'(cfg_high);
            if (p >= d) p = (d == 0) ? 0 : d - 1;
            if (h == 0) h = 1;
            if (h >= d && d >= 2) h = d - 1;
            m_div[cfg_ch] = d;
            m_ph[cfg_ch]  = p;
            m_hi[cfg_ch]  = h;
            m_a = m_n + 1;
         end
         e.rdy = (m_n >= m_a);
         e.lck = (m_n >= m_a + LC);
      end
      e.n = m_n;
      q.push_back(e);
   end

   // Monitor: one expected entry per refclk edge, compared mid-cycle.
   exp_t r;
   always @(negedge refclk) begin
      if (q.size() > 0) begin
         r = q.pop_front();
         check("outclk", 32'(outclk), 32'(r.clk), r.n);
         check("outce", 32'(outce), 32'(r.ce), r.n);
         check("locked", 32'(locked), 32'(r.lck), r.n);
         check("cfg_ready", 32'(cfg_ready), 32'(r.rdy), r.n);
      end
   end

   task automatic idle(input int nc);
      repeat (nc) @(negedge refclk);
      #1;
   endtask

   task automatic write(input int ch, input int dv, input int ph, input int hi);
      int waited;
      waited    = 0;
      cfg_ch    = CW'(ch);
      cfg_div   = DW'(dv);
      cfg_phase = DW'(ph);
      cfg_high  = DW'(hi);
      cfg_valid = 1'b1;
      while (cfg_ready !== 1'b1 && waited < 60) begin
         @(negedge refclk);
         #1;
         waited++;
      end
      check("handshake", 32'(cfg_ready), 32'd1, m_n);
      @(negedge refclk);
      #1;
      cfg_valid = 1'b0;
   endtask

   initial begin
      #1;
      check("rst_outclk", 32'(outclk), 32'd0, 0);
      check("rst_outce", 32'(outce), 32'd0, 0);
      check("rst_locked", 32'(locked), 32'd0, 0);
      check("rst_ready", 32'(cfg_ready), 32'd0, 0);
      idle(3);
      rst = 1'b0;
      idle(25);

      write(0, 5, 0, 2);
      write(1, 5, 3, 2);
      idle(25);

      write(2, 4, 9, 0);
      idle(22);

      write(0, 1, 0, 1);
      write(1, 0, 0, 1);
      idle(22);

      write(2, 6, 1, 3);
      idle(5);
      write(0, 7, 2, 4);
      idle(22);
      write(3, 3, 1, 1);
      idle(10);

      // One-cycle reset pulse while locked; outputs must clear without a clock edge.
      rst = 1'b1;
      #1;
      check("async_outclk", 32'(outclk), 32'd0, m_n);
      check("async_outce", 32'(outce), 32'd0, m_n);
      check("async_locked", 32'(locked), 32'd0, m_n);
      check("async_ready", 32'(cfg_ready), 32'd0, m_n);
      idle(1);
      rst = 1'b0;
      idle(25);

      for (int i = 0; i < 24; i++) begin
         write(int'($urandom_range(0, NCH)), int'($urandom_range(0, 12)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         idle(int'($urandom_range(0, 30)));
      end
      idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
